uart_transmitter: RTL and testbench

- Serialises one byte per handshake onto an 8N1 UART line: 1 start bit (low), 8 data bits, 1 stop bit (high).
- Sits directly upstream of uart_receiver on the serial link. It drives the line that the receiver samples, so both share the same per-bit cycle count.
- Byte source, e.g. a command/echo block, presents data with a valid/ready handshake.

---
 rtl/uart_transmitter.sv | 110 +++++++++++
 tb/tb_uart_transmitter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 UART transmitter with valid/ready byte input; optional UART_TX_TWO_STOP_EN adds a second stop bit
module uart_transmitter #(
  parameter int unsigned FULL_BIT = 697394
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic [0:7] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

  localparam logic [23:0] LAST_COUNT = 24'(FULL_BIT - 1);

  state_t      state, state_n;
  logic [23:0] count, count_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [0:7]  latch, latch_n;
  logic        tx_n;
  logic        bit_end;

  assign bit_end = (count == LAST_COUNT);
  assign o_ready = (state == IDLE);
  assign o_busy  = ~o_ready;

  // State and datapath registers; reset forces the line high at once
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      count   <= 24'd0;
      bit_idx <= 3'd0;
      latch   <= 8'd0;
      o_tx    <= 1'b1;
    end else begin
      state   <= state_n;
      count   <= count_n;
      bit_idx <= bit_idx_n;
      latch   <= latch_n;
      o_tx    <= tx_n;
    end
  end

  // Next-state logic; o_tx is computed one cycle ahead so it leaves a flop
  always_comb begin
    state_n   = state;
    count_n   = bit_end ? 24'd0 : count + 24'd1;
    bit_idx_n = bit_idx;
    latch_n   = latch;
    tx_n      = o_tx;
    case (state)
      IDLE: begin
        count_n = 24'd0;
        tx_n    = 1'b1;
        if (i_valid) begin
          latch_n = i_data;
          state_n = START_BIT;
          tx_n    = 1'b0;
        end
      end
      START_BIT: begin
        if (bit_end) begin
          state_n   = DATA_BITS;
          bit_idx_n = 3'd0;
          tx_n      = latch[0];
        end
      end
      DATA_BITS: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_n   = STOP_BIT;
            bit_idx_n = 3'd0;
            tx_n      = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = latch[bit_idx_n];
          end
        end
      end
      STOP_BIT: begin
        tx_n = 1'b1;
        if (bit_end) begin
`ifdef UART_TX_TWO_STOP_EN
          // bit index counts the stop-bit passes: 0 = first, 1 = second
          if (bit_idx == 3'd0) begin
            bit_idx_n = 3'd1;
          end else begin
            bit_idx_n = 3'd0;
            state_n   = IDLE;
          end
`else
          state_n = IDLE;
`endif
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter
module tb_uart_transmitter;

  localparam int FB = 16;
`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_N = 2;
`else
  localparam int STOP_N = 1;
`endif
  localparam int FRAME = (9 + STOP_N) * FB;

  logic       clk;
  logic       i_reset;
  logic [0:7] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       o_tx;
  logic       o_busy;

  int errors = 0;
  int checks = 0;

  logic       exp_tx_q[$];
  logic       exp_rdy_q[$];
  logic [0:7] rx_q[$];

  uart_transmitter #(.FULL_BIT(FB)) dut (
    .clk     (clk),
    .i_reset (i_reset),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_tx    (o_tx),
    .o_busy  (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the line: one entry per clock cycle after the acceptance edge
  task automatic push_frame(input logic [0:7] b);
    for (int c = 0; c < FB; c++) begin exp_tx_q.push_back(1'b0); exp_rdy_q.push_back(1'b0); end
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < FB; c++) begin exp_tx_q.push_back(b[i]); exp_rdy_q.push_back(1'b0); end
    for (int c = 0; c < STOP_N * FB; c++) begin exp_tx_q.push_back(1'b1); exp_rdy_q.push_back(1'b0); end
  endtask

  task automatic push_idle(input int n);
    for (int c = 0; c < n; c++) begin exp_tx_q.push_back(1'b1); exp_rdy_q.push_back(1'b1); end
  endtask

  task automatic accept_byte(input logic [0:7] b);
    @(posedge clk); #1;
    i_data  = b;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge clk); #3;
    i_reset = 1'b1;
    #1;
    checks++;
    if (o_tx !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: tx=%b ready=%b busy=%b, required 1 1 0", o_tx, o_ready, o_busy);
    end
    @(posedge clk); #1;
    i_reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (o_tx !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: tx=%b ready=%b busy=%b, required 1 1 0", k, o_tx, o_ready, o_busy);
      end
    end
  endtask

  task automatic test_single_frame;
    int low_rdy = 0;
    accept_byte(8'b1000_0000);
    push_frame(8'b1000_0000);
    push_idle(3);
    for (int k = 0; exp_tx_q.size() > 0; k++) begin
      logic et, er;
      @(negedge clk);
      et = exp_tx_q.pop_front();
      er = exp_rdy_q.pop_front();
      if (o_ready === 1'b0) low_rdy++;
      checks++;
      if (o_tx !== et || o_ready !== er || o_busy !== ~er) begin
        errors++;
        $display("FAIL single_frame cycle %0d: tx=%b ready=%b busy=%b, required %b %b %b", k, o_tx, o_ready, o_busy, et, er, ~er);
      end
    end
    checks++;
    if (low_rdy != FRAME) begin
      errors++;
      $display("FAIL single_ready_low: %0d cycles, required %0d", low_rdy, FRAME);
    end
  endtask

  task automatic test_back_to_back;
    int   fall[$];
    logic prev = 1'b1;
    @(posedge clk); #1;
    i_data  = 8'hA5;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_data  = 8'h3C;
    push_frame(8'hA5);
    push_idle(1);
    push_frame(8'h3C);
    push_idle(3);
    for (int k = 0; exp_tx_q.size() > 0; k++) begin
      logic et, er;
      @(negedge clk);
      if (k == FRAME + 5) i_valid = 1'b0;
      et = exp_tx_q.pop_front();
      er = exp_rdy_q.pop_front();
      if (prev === 1'b1 && o_tx === 1'b0) fall.push_back(k);
      prev = o_tx;
      checks++;
      if (o_tx !== et || o_ready !== er) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: tx=%b ready=%b, required %b %b", k, o_tx, o_ready, et, er);
      end
    end
    checks++;
    if (fall.size() < 2 || (fall[fall.size()-1] - fall[0]) != 0 && fall.size() < 2) begin
      errors++;
      $display("FAIL b2b_falls: %0d falling edges seen, required at least 2", fall.size());
    end else begin
      int first_start = fall[0];
      int second_start = -1;
      foreach (fall[i]) if (second_start < 0 && fall[i] >= first_start + FRAME) second_start = fall[i];
      checks++;
      if (second_start - first_start != FRAME + 1) begin
        errors++;
        $display("FAIL b2b_spacing: %0d cycles, required %0d", second_start - first_start, FRAME + 1);
      end
    end
  endtask

  task automatic test_busy_ignored;
    accept_byte(8'hFF);
    push_frame(8'hFF);
    push_idle(3);
    for (int k = 0; exp_tx_q.size() > 0; k++) begin
      logic et, er;
      @(negedge clk);
      if (k == 40) begin i_data = 8'h00; i_valid = 1'b1; end
      if (k == 41) i_valid = 1'b0;
      if (k == 70) i_data = 8'h0F;
      et = exp_tx_q.pop_front();
      er = exp_rdy_q.pop_front();
      checks++;
      if (o_tx !== et || o_ready !== er) begin
        errors++;
        $display("FAIL busy_ignored cycle %0d: tx=%b ready=%b, required %b %b", k, o_tx, o_ready, et, er);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    accept_byte(8'h00);
    repeat (51) @(negedge clk);
    checks++;
    if (o_tx !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_pre: tx=%b busy=%b, required 0 1", o_tx, o_busy);
    end
    #2;
    i_reset = 1'b1;
    #1;
    checks++;
    if (o_tx !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL midframe_async: tx=%b ready=%b busy=%b, required 1 1 0", o_tx, o_ready, o_busy);
    end
    @(posedge clk); #1;
    i_reset = 1'b0;
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1 || o_tx !== 1'b1) begin
      errors++;
      $display("FAIL midframe_release: ready=%b tx=%b, required 1 1", o_ready, o_tx);
    end
    accept_byte(8'h5A);
    push_frame(8'h5A);
    push_idle(2);
    for (int k = 0; exp_tx_q.size() > 0; k++) begin
      logic et, er;
      @(negedge clk);
      et = exp_tx_q.pop_front();
      er = exp_rdy_q.pop_front();
      checks++;
      if (o_tx !== et || o_ready !== er) begin
        errors++;
        $display("FAIL after_reset cycle %0d: tx=%b ready=%b, required %b %b", k, o_tx, o_ready, et, er);
      end
    end
  endtask

  task automatic test_loopback;
    logic [0:7] bytes [4] = '{8'h00, 8'h55, 8'hAA, 8'hFF};
    foreach (bytes[n]) begin
      logic [0:7] rx;
      logic       start_s;
      logic       stop_ok;
      logic [0:7] exp_b;
      accept_byte(bytes[n]);
      rx_q.push_back(bytes[n]);
      start_s = 1'b1;
      stop_ok = 1'b1;
      rx      = 8'h00;
      for (int k = 0; k <= FRAME; k++) begin
        @(negedge clk);
        if (k == FB / 2) start_s = o_tx;
        for (int i = 0; i < 8; i++)
          if (k == (i + 1) * FB + FB / 2) rx[i] = o_tx;
        for (int s = 0; s < STOP_N; s++)
          if (k == (9 + s) * FB + FB / 2 && o_tx !== 1'b1) stop_ok = 1'b0;
      end
      exp_b = rx_q.pop_front();
      checks++;
      if (rx !== exp_b || start_s !== 1'b0 || stop_ok !== 1'b1) begin
        errors++;
        $display("FAIL loopback byte %0d: data=%h start=%b stop_ok=%b, required data=%h start=0 stop_ok=1", n, rx, start_s, stop_ok, exp_b);
      end
      checks++;
      if (o_ready !== 1'b1) begin
        errors++;
        $display("FAIL loopback_idle byte %0d: ready=%b, required 1", n, o_ready);
      end
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;
    repeat (3) @(posedge clk);
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_busy_ignored;
    test_reset_mid_frame;
    test_loopback;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
